multi_debouncer: RTL and testbench

Parametrised N-channel debouncer for the board push-buttons and switches. Each channel synchronises its raw input, filters bounce with a saturating stability counter, and produces a clean level plus one-cycle rise/fall strobes. Optional hold-to-repeat support generates long-press and auto-repeat strobes. Sits between the raw pins and all user-input FSMs, replacing per-button single-channel debouncers.

---
 rtl/multi_debouncer_if.sv | 29 ++
 rtl/multi_debouncer.sv | 157 +++++++++++++++
 tb/tb_multi_debouncer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/multi_debouncer_if.sv
// Raw pin inputs and debounced level/strobe outputs of the multi-channel debouncer.
interface multi_debouncer_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_out;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic [N_CH-1:0] btn_repeat;
    logic [N_CH-1:0] btn_long;

    modport master (
        output btn_in,
        input  btn_out,
        input  btn_rise,
        input  btn_fall,
        input  btn_repeat,
        input  btn_long
    );

    modport slave (
        input  btn_in,
        output btn_out,
        output btn_rise,
        output btn_fall,
        output btn_repeat,
        output btn_long
    );
endinterface

// File: rtl/multi_debouncer.sv
// N independent channels: 2-flop sync, saturating stability filter, edge strobes and
// a hold FSM producing long-press / auto-repeat strobes.
//
//   state    | meaning
//   S_IDLE   | released, or pressed before any commit
//   S_HOLD   | committed press, counting towards the long-press strobe
//   S_REPEAT | long-press reached, strobing every REPEAT_COUNT cycles
//   S_LONG   | long-press reached, repeat disabled; wait for release
module multi_debouncer #(
    parameter int          N_CH           = 4,
    parameter logic [31:0] DEBOUNCE_COUNT = 32'd12_500_000,
    parameter logic [31:0] HOLD_COUNT     = 32'd50_000_000,
    parameter logic [31:0] REPEAT_COUNT   = 32'd12_500_000,
    parameter bit          REPEAT_EN      = 1'b1
) (
    input logic              clk,
    input logic              rst,
    multi_debouncer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT, S_LONG} hold_state_t;

    localparam logic [31:0] DB_TC   = DEBOUNCE_COUNT - 32'd1;
    localparam logic [31:0] HOLD_TC = HOLD_COUNT - 32'd1;
    localparam logic [31:0] REP_TC  = REPEAT_COUNT - 32'd1;

    logic [N_CH-1:0] out_vec;
    logic [N_CH-1:0] rise_vec;
    logic [N_CH-1:0] fall_vec;
    logic [N_CH-1:0] rep_vec;
    logic [N_CH-1:0] long_vec;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic        sync1;
        logic        sync2;
        logic        cand;
        logic [31:0] cnt;
        logic        out_q;
        logic        rise_q;
        logic        fall_q;
        logic        rep_q;
        logic        long_q;
        logic [31:0] hcnt;
        logic [31:0] hcnt_nxt;
        logic        rep_nxt;
        logic        long_nxt;
        logic        commit;
        logic        rise_c;
        logic        fall_c;
        hold_state_t state;
        hold_state_t state_nxt;

        assign commit = (sync2 == cand) && (cnt == DB_TC);
        assign rise_c = commit && cand && !out_q;
        assign fall_c = commit && !cand && out_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                cand   <= 1'b0;
                cnt    <= '0;
                out_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync1 <= bus.btn_in[i];
                sync2 <= sync1;
                // cnt stops at DEBOUNCE_COUNT so a long-stable level commits only once
                if (sync2 != cand) begin
                    cand <= sync2;
                    cnt  <= '0;
                end else if (cnt < DEBOUNCE_COUNT) begin
                    cnt <= cnt + 32'd1;
                end
                if (commit) begin
                    out_q <= cand;
                end
                rise_q <= rise_c;
                fall_q <= fall_c;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= S_IDLE;
                hcnt   <= '0;
                rep_q  <= 1'b0;
                long_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                hcnt   <= hcnt_nxt;
                rep_q  <= rep_nxt;
                long_q <= long_nxt;
            end
        end

        // A release commit overrides any terminal count landing on the same edge.
        always_comb begin
            state_nxt = state;
            hcnt_nxt  = hcnt;
            rep_nxt   = 1'b0;
            long_nxt  = long_q;
            if (fall_c) begin
                state_nxt = S_IDLE;
                hcnt_nxt  = '0;
                long_nxt  = 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (rise_c) begin
                            state_nxt = S_HOLD;
                            hcnt_nxt  = '0;
                        end
                    end
                    S_HOLD: begin
                        if (hcnt == HOLD_TC) begin
                            rep_nxt   = 1'b1;
                            long_nxt  = 1'b1;
                            hcnt_nxt  = '0;
                            state_nxt = REPEAT_EN ? S_REPEAT : S_LONG;
                        end else begin
                            hcnt_nxt = hcnt + 32'd1;
                        end
                    end
                    S_REPEAT: begin
                        if (hcnt == REP_TC) begin
                            rep_nxt  = 1'b1;
                            hcnt_nxt = '0;
                        end else begin
                            hcnt_nxt = hcnt + 32'd1;
                        end
                    end
                    S_LONG: begin
                        state_nxt = S_LONG;
                    end
                    default: begin
                        state_nxt = S_IDLE;
                        hcnt_nxt  = '0;
                        long_nxt  = 1'b0;
                    end
                endcase
            end
        end

        assign out_vec[i]  = out_q;
        assign rise_vec[i] = rise_q;
        assign fall_vec[i] = fall_q;
        assign rep_vec[i]  = rep_q;
        assign long_vec[i] = long_q;
    end

    assign bus.btn_out    = out_vec;
    assign bus.btn_rise   = rise_vec;
    assign bus.btn_fall   = fall_vec;
    assign bus.btn_repeat = rep_vec;
    assign bus.btn_long   = long_vec;
endmodule

// File: tb/tb_multi_debouncer.sv
// Directed scenarios plus randomized traffic on two debouncers (repeat on / off),
// checked against a run-length and time-since-press reference model.
module tb_multi_debouncer;
    localparam int N = 4;
    localparam int D = 8;
    localparam int H = 20;
    localparam int R = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    multi_debouncer_if #(.N_CH(N)) bus_a ();
    multi_debouncer_if #(.N_CH(N)) bus_b ();

    assign bus_a.btn_in = btn;
    assign bus_b.btn_in = btn;

    multi_debouncer #(
        .N_CH(N), .DEBOUNCE_COUNT(32'd8), .HOLD_COUNT(32'd20),
        .REPEAT_COUNT(32'd5), .REPEAT_EN(1'b1)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    multi_debouncer #(
        .N_CH(N), .DEBOUNCE_COUNT(32'd8), .HOLD_COUNT(32'd20),
        .REPEAT_COUNT(32'd5), .REPEAT_EN(1'b0)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Reference model state: sample delay, run length of the delayed stream, press time
    logic [N-1:0] d1, d2, run_lvl;
    int           run_len [N];
    int           rise_at [N];
    int           edge_j;
    logic [N-1:0] m_out, m_rise, m_fall, m_rep_a, m_rep_b, m_long_a, m_long_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        d1 = '0; d2 = '0; run_lvl = '0;
        m_out = '0; m_rise = '0; m_fall = '0;
        m_rep_a = '0; m_rep_b = '0; m_long_a = '0; m_long_b = '0;
        for (int c = 0; c < N; c++) begin
            run_len[c] = 1;
            rise_at[c] = 0;
        end
        edge_j = 0;
    endtask

    task automatic model_step(input logic [N-1:0] smp);
        for (int c = 0; c < N; c++) begin
            logic s;
            int   t;
            s = d2[c];
            d2[c] = d1[c];
            d1[c] = smp[c];
            if (s == run_lvl[c]) begin
                if (run_len[c] < 1000000) run_len[c]++;
            end else begin
                run_lvl[c] = s;
                run_len[c] = 1;
            end
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (run_len[c] == D + 1 && run_lvl[c] != m_out[c]) begin
                m_rise[c] = run_lvl[c];
                m_fall[c] = !run_lvl[c];
                m_out[c]  = run_lvl[c];
            end
            m_rep_a[c] = 1'b0;
            m_rep_b[c] = 1'b0;
            if (m_rise[c]) begin
                rise_at[c]  = edge_j;
                m_long_a[c] = 1'b0;
                m_long_b[c] = 1'b0;
            end else if (!m_out[c]) begin
                m_long_a[c] = 1'b0;
                m_long_b[c] = 1'b0;
            end else begin
                t = edge_j - rise_at[c];
                m_rep_a[c]  = (t == H) || (t > H && ((t - H) % R) == 0);
                m_rep_b[c]  = (t == H);
                m_long_a[c] = (t >= H);
                m_long_b[c] = (t >= H);
            end
        end
        edge_j++;
    endtask

    task automatic tick();
        logic [N-1:0] smp;
        @(posedge clk);
        smp = btn;
        if (rst) model_reset();
        else model_step(smp);
        #1;
        check("out_a",  32'(bus_a.btn_out),    32'(m_out));
        check("rise_a", 32'(bus_a.btn_rise),   32'(m_rise));
        check("fall_a", 32'(bus_a.btn_fall),   32'(m_fall));
        check("rep_a",  32'(bus_a.btn_repeat), 32'(m_rep_a));
        check("long_a", 32'(bus_a.btn_long),   32'(m_long_a));
        check("out_b",  32'(bus_b.btn_out),    32'(m_out));
        check("rise_b", 32'(bus_b.btn_rise),   32'(m_rise));
        check("fall_b", 32'(bus_b.btn_fall),   32'(m_fall));
        check("rep_b",  32'(bus_b.btn_repeat), 32'(m_rep_b));
        check("long_b", 32'(bus_b.btn_long),   32'(m_long_b));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, 32'({bus_a.btn_out, bus_a.btn_rise, bus_a.btn_fall,
                                bus_a.btn_repeat, bus_a.btn_long}), 32'd0);
        check({tag, "_b"}, 32'({bus_b.btn_out, bus_b.btn_rise, bus_b.btn_fall,
                                bus_b.btn_repeat, bus_b.btn_long}), 32'd0);
    endtask

    initial begin
        int na, nb;
        int left [N];

        model_reset();
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (5) tick();

        // Clean press on ch0: commit on the 11th edge counting the first sample edge
        btn[0] = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            tick();
            check("s1_out", 32'(bus_a.btn_out),  (t == 11) ? 32'h1 : 32'h0);
            check("s1_rise", 32'(bus_a.btn_rise), (t == 11) ? 32'h1 : 32'h0);
        end
        // Hold/repeat, release timed so the fall lands on a repeat terminal count
        for (int t = 1; t <= 35; t++) begin
            tick();
            check("s4_rep_a",  32'(bus_a.btn_repeat[0]), 32'(t == 20 || t == 25 || t == 30));
            check("s4_rep_b",  32'(bus_b.btn_repeat[0]), 32'(t == 20));
            check("s4_long_a", 32'(bus_a.btn_long[0]),   32'(t >= 20 && t < 35));
            check("s4_long_b", 32'(bus_b.btn_long[0]),   32'(t >= 20 && t < 35));
            check("s4_fall",   32'(bus_a.btn_fall[0]),   32'(t == 35));
            check("s4_out",    32'(bus_a.btn_out[0]),    32'(t < 35));
            if (t == 24) btn[0] = 1'b0;
        end
        repeat (15) tick();

        // Glitch on ch1: 8 samples high never commits
        btn[1] = 1'b1;
        for (int t = 1; t <= 28; t++) begin
            tick();
            if (t == 8) btn[1] = 1'b0;
            check("s2_glitch_out",  32'(bus_a.btn_out[1]),  32'd0);
            check("s2_glitch_rise", 32'(bus_a.btn_rise[1]), 32'd0);
        end
        // 9 samples high commits, then the low level commits back
        btn[1] = 1'b1;
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (t == 9) btn[1] = 1'b0;
            check("s2_pulse_out",  32'(bus_a.btn_out[1]),  32'(t >= 11 && t < 20));
            check("s2_pulse_rise", 32'(bus_a.btn_rise[1]), 32'(t == 11));
            check("s2_pulse_fall", 32'(bus_a.btn_fall[1]), 32'(t == 20));
        end

        // Bounce on ch2: 1,0,1,0 then held 1 from the 5th sample
        for (int t = 1; t <= 20; t++) begin
            btn[2] = (t >= 5) ? 1'b1 : 1'(t % 2);
            tick();
            check("s3_rise", 32'(bus_a.btn_rise[2]), 32'(t == 15));
            check("s3_out",  32'(bus_a.btn_out[2]),  32'(t >= 15));
        end
        btn[2] = 1'b0;
        repeat (12) tick();

        // Long hold on ch3: one strobe with repeat off, periodic strobes with repeat on
        btn[3] = 1'b1;
        na = 0;
        nb = 0;
        for (int t = 1; t <= 111; t++) begin
            tick();
            if (bus_a.btn_repeat[3]) na++;
            if (bus_b.btn_repeat[3]) nb++;
        end
        check("s5_rep_count_b", 32'(nb), 32'd1);
        check("s5_rep_count_a", 32'(na), 32'd17);
        check("s5_long_b", 32'(bus_b.btn_long[3]), 32'd1);
        btn[3] = 1'b0;
        repeat (12) tick();
        check("s5_long_b_rel", 32'(bus_b.btn_long[3]), 32'd0);

        // Reset during REPEAT with three channels pressed
        btn = 4'b0111;
        repeat (40) tick();
        check("s6_pre_long", 32'(bus_a.btn_long), 32'h7);
        rst = 1'b1;
        #1;
        check_all_zero("s6_async");
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        for (int t = 1; t <= 11; t++) begin
            tick();
            check("s6_out",  32'(bus_a.btn_out),  (t == 11) ? 32'h7 : 32'h0);
            check("s6_rise", 32'(bus_a.btn_rise), (t == 11) ? 32'h7 : 32'h0);
        end
        btn = '0;
        repeat (15) tick();

        // Randomized per-channel levels with mixed short (bouncy) and long holds
        for (int c = 0; c < N; c++) left[c] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (left[c] == 0) begin
                    btn[c]  = ~btn[c];
                    left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                          : int'($urandom_range(1, 10));
                end else begin
                    left[c]--;
                end
            end
            if (cyc == 2000) rst = 1'b1;
            if (cyc == 2003) rst = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
